// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// Module      : mem_responder
// Description : Word-addressed memory responder with programmable wait states,
//               req/ack handshake and error response for bad addresses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int         DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [3:0] C_WAIT = WAIT[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    we_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             mem_q [DEPTH];

    logic [29:0]             word_addr;
    logic                    addr_bad;
    logic                    access_now;
    logic                    mem_wr;

    assign word_addr  = addr[31:2];
    assign addr_bad   = (addr[1:0] != 2'b00) || ((word_addr >> DEPTH_LOG2) != 30'd0);
    assign access_now = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // Reset gates the write so a transaction dropped by reset never lands.
    assign mem_wr     = access_now && we_q && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        idx_q   <= addr[DEPTH_LOG2+1:2];
                        we_q    <= we;
                        wdata_q <= wdata;
                        if (addr_bad) begin
                            state_q <= S_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= C_WAIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!we_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= S_RESP;
                        ack_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder for the multicycle CPU's combined instruction/data memory port. It accepts one request at a time from the CPU-side controller over a req/ack handshake. It inserts a configurable number of wait states, then performs the read or write and pulses ack for one cycle. Misaligned and out-of-range accesses are rejected with an error response and never touch the array.

## Interface
Parameters:
- DEPTH_LOG2, default 8: log2 of the number of 32-bit words; the array holds 2^DEPTH_LOG2 words.
- WAIT, default 2: number of wait-state cycles before the access; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  write data; sampled with req.
- rdata  output  32  read data; updated only by a successful read.
- ack  output  1  one-cycle completion pulse.
- err  output  1  error flag; high only together with ack.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP. A 4-bit wait counter cnt is used. Request registers hold addr, we and wdata.
- IDLE with req=1 at an edge (the acceptance edge, E0):
  - addr, we and wdata are latched.
  - If addr[1:0] != 0, or addr[31:2] >= 2^DEPTH_LOG2, the request is an error: go to RESP with err pending.
  - Otherwise go to BUSY with cnt = WAIT.
- IDLE with req=0: stay in IDLE.
- BUSY with cnt != 0: cnt decrements by 1 per edge.
- BUSY with cnt == 0: the access happens at that edge, then the state moves to RESP.
  - Write: mem[addr[DEPTH_LOG2+1:2]] <= wdata.
  - Read: rdata <= mem[addr[DEPTH_LOG2+1:2]].
- RESP: ack=1 for this single cycle; err=1 if the request was an error. The next edge returns to IDLE.
- req, we, addr and wdata are ignored in BUSY and RESP. Changing them after E0 has no effect on the transaction in flight.
- rdata holds its value across writes, errors and idle time. It changes only at the edge completing a valid read.
- Error requests never write the array and never change rdata.
- Array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset (any state, any cycle): state=IDLE, cnt=0, ack=0, err=0, busy=0, rdata=0.
  - A transaction in flight is dropped. A pending write is not performed.
- Valid request: ack is high in the cycle after edge E(WAIT+1), i.e. a latency of WAIT+1 edges from acceptance.
  - The array/rdata update coincides with the ack rising edge.
- Error request: ack=err=1 in the cycle after E0, regardless of WAIT.
- busy is high from the cycle after E0 through the RESP cycle inclusive.
- Back-to-back throughput with req held high:
  - Valid requests: the next acceptance is at E(WAIT+3), i.e. one every WAIT+3 cycles.
  - Error requests: one every 2 cycles.
- WAIT=0: BUSY lasts exactly one cycle, and ack is high in the cycle after E1.
- ack and err are registered outputs; neither is ever high for more than one consecutive cycle.

## Test plan
- Reset mid-BUSY: write 0x12345678 to 0x20, assert rst one cycle after E0. Required: ack=err=busy=0 and rdata=0 immediately. A later read of 0x20 returns the previous contents, not 0x12345678.
- Write/read, WAIT=2: write 0xDEADBEEF to 0x10. Required: ack high exactly in the cycle after E3, err=0, rdata unchanged. Then read 0x10: rdata=0xDEADBEEF in the ack cycle, and it holds afterwards.
- Misaligned: write to 0x13 with req held one cycle. Required: ack=err=1 in the cycle after E0, busy high for only that cycle. A following read of 0x10 still returns 0xDEADBEEF.
- Out of range, DEPTH_LOG2=8: read 0x400. Required: ack=err=1 after E0, and rdata keeps its prior value.
- req held high, WAIT=2, with addr changed to 0x14 during BUSY. Required: the first transaction uses 0x10, acceptances occur every 5 cycles, and no ack arrives during BUSY.
- WAIT=0: write 0xA5A5A5A5 to 0x0 then read it back. Required: each ack occurs in the cycle after E1, the read returns 0xA5A5A5A5, and acceptances are spaced 3 cycles apart.
